mem_stage: RTL

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/M pipeline register and upstream of the M/WB register. It performs loads and stores against a variable-latency data-memory port using a request/ready handshake, and stalls the front of the pipeline while an access is outstanding. It also resolves taken branches and produces the write-back result and destination-register index.

---
 rtl/mem_stage.sv | 90 +++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with a req/ready data-memory port, front-end stall, branch resolve and write-back mux
module mem_stage #(
  parameter bit SIGN_EXT_BYTE = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [31:0]      address_in,
  input  logic [31:0]      next_pc_in,
  input  logic             ALU_zero_in,
  input  logic [31:0]      data_in,
  input  logic [5:0]       control_in,
  input  logic [4:0]       rgD_index_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             stall_out,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_rgD_index,
  output logic             wb_reg_write,
  output logic             pc_src,
  output logic [31:0]      branch_target,
  output logic             flush_out,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        we_q, byte_q;
  logic        reg_write, mem_read, mem_write, mem_to_reg, branch, byte_acc;
  logic        idle, mem_op, go;
  logic [7:0]  lbyte;
  logic [31:0] load;
  assign {byte_acc, branch, mem_to_reg, mem_write, mem_read, reg_write} = control_in;
  assign idle     = state == IDLE;
  assign mem_op   = valid_in & (mem_read | mem_write);
  assign misalign = idle & mem_op & ~byte_acc & (address_in[1:0] != 2'b00);
  assign go       = idle & mem_op & ~misalign;
  assign lbyte    = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign load     = byte_q ? {{24{SIGN_EXT_BYTE & lbyte[7]}}, lbyte} : rdata_q;
  assign stall_out     = go | (state == REQ);
  assign wb_valid      = valid_in & ~stall_out;
  // Inputs are frozen by the stall, so DONE still sees the issuing instruction's control.
  assign wb_data       = (state == DONE && mem_to_reg) ? load : address_in;
  assign wb_reg_write  = reg_write & ~mem_write & ~misalign;
  assign wb_rgD_index  = rgD_index_in;
  assign pc_src        = idle & valid_in & branch & ALU_zero_in;
  assign flush_out     = pc_src;
  assign branch_target = next_pc_in;
  assign mem_req       = state == REQ;
  assign mem_we        = we_q;
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (stall_out && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (go) begin
        state   <= REQ;
        addr_q  <= address_in;
        we_q    <= mem_write;
        byte_q  <= byte_acc;
        be_q    <= byte_acc ? 4'b0001 << address_in[1:0] : 4'b1111;
        wdata_q <= byte_acc ? {4{data_in[7:0]}} : data_in;
      end else if (state == REQ && mem_ready) begin
        state   <= DONE;
        rdata_q <= mem_rdata;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule
